// File: rtl/sqr_ref_gen_pkg.sv
// Shared definitions for the square-wave reference generator: default widths
// and the controller state encoding.
package sqr_ref_gen_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IDX_WIDTH  = 9;
  localparam int DEF_PER_WIDTH  = 9;

  // REDUCE is a sub-state of RUN: busy is high but no sample is offered yet.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sqr_ref_gen_level_map.sv
// Maps a high/low decision onto an output code. High level is the amplitude;
// low level mirrors it about mid-code and saturates to full scale when amp=0.
// Kept separate so other waveform generators can share the same mapping.
module sqr_level_map #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] amp,
  input  logic                  invert,
  input  logic                  high_bit,
  output logic [DATA_WIDTH-1:0] level
);

  localparam logic [DATA_WIDTH:0] TWO_MID = {1'b1, {DATA_WIDTH{1'b0}}};

  logic [DATA_WIDTH:0]   low_full;
  logic [DATA_WIDTH-1:0] low_level;

  // Mirror about mid-code in DATA_WIDTH+1 bits, clamp the one overflow case.
  always_comb begin
    low_full  = TWO_MID - {1'b0, amp};
    low_level = low_full[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : low_full[DATA_WIDTH-1:0];
    level     = (high_bit ^ invert) ? amp : low_level;
  end

endmodule

// File: rtl/sqr_ref_gen.sv
// Streams one programmable square-wave reference frame over valid/ready.
// Config is captured on start; the start phase is reduced modulo the period by
// repeated subtraction before the first sample is offered.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | waiting for start; outputs hold their last values, valid=0
//  ST_REDUCE | phase -= period until phase < period; busy=1, valid=0
//  ST_RUN    | offering samples; abort returns to idle without done
//  ST_DONE   | one-cycle done pulse after the last handshake
module sqr_ref_gen
  import sqr_ref_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int PER_WIDTH  = DEF_PER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IDX_WIDTH-1:0]  cfg_len,
  input  logic [PER_WIDTH-1:0]  cfg_period,
  input  logic [PER_WIDTH-1:0]  cfg_duty,
  input  logic [PER_WIDTH-1:0]  cfg_phase,
  input  logic                  cfg_invert,
  input  logic [DATA_WIDTH-1:0] cfg_amp,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_t state, state_nxt;

  logic [IDX_WIDTH-1:0]  len_r;
  logic [PER_WIDTH-1:0]  period_r;
  logic [PER_WIDTH-1:0]  duty_r;
  logic [PER_WIDTH-1:0]  phase_r;
  logic                  invert_r;
  logic [DATA_WIDTH-1:0] amp_r;
  logic [PER_WIDTH-1:0]  ph_r;

  logic                  phase_reduced;
  logic                  latch_cfg;
  logic                  load_first;
  logic                  advance;
  logic [PER_WIDTH-1:0]  ph_inc;
  logic [PER_WIDTH-1:0]  ph_sel;
  logic [DATA_WIDTH-1:0] level;

  assign phase_reduced = (phase_r < period_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort takes priority over a handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_REDUCE;
      ST_REDUCE: begin
        if (abort)              state_nxt = ST_IDLE;
        else if (phase_reduced) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                              state_nxt = ST_IDLE;
        else if (out_valid && out_ready && out_last) state_nxt = ST_DONE;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs and datapath strobes decoded from the current state.
  always_comb begin
    out_valid  = (state == ST_RUN);
    busy       = (state == ST_REDUCE) || (state == ST_RUN);
    done       = (state == ST_DONE);
    latch_cfg  = (state == ST_IDLE) && start;
    load_first = (state == ST_REDUCE) && !abort && phase_reduced;
    advance    = (state == ST_RUN) && !abort && out_ready && !out_last;
  end

  // Phase of the sample about to be registered: reduced start phase on load,
  // otherwise the wrapping successor of the current phase.
  always_comb begin
    ph_inc = (ph_r == period_r - PER_WIDTH'(1)) ? '0 : ph_r + PER_WIDTH'(1);
    ph_sel = load_first ? phase_r : ph_inc;
  end

  sqr_level_map #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_level_map (
    .amp      (amp_r),
    .invert   (invert_r),
    .high_bit (ph_sel < duty_r),
    .level    (level)
  );

  // Config capture, phase reduction and the registered output sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r    <= '0;
      period_r <= PER_WIDTH'(1);
      duty_r   <= '0;
      phase_r  <= '0;
      invert_r <= 1'b0;
      amp_r    <= '0;
      ph_r     <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      if (latch_cfg) begin
        len_r    <= cfg_len;
        period_r <= (cfg_period == '0) ? PER_WIDTH'(1) : cfg_period;
        duty_r   <= cfg_duty;
        phase_r  <= cfg_phase;
        invert_r <= cfg_invert;
        amp_r    <= cfg_amp;
      end
      if ((state == ST_REDUCE) && !phase_reduced) phase_r <= phase_r - period_r;
      if (load_first) begin
        ph_r     <= ph_sel;
        out_data <= level;
        out_idx  <= '0;
        out_last <= (len_r == '0);
      end else if (advance) begin
        ph_r     <= ph_sel;
        out_data <= level;
        out_idx  <= out_idx + IDX_WIDTH'(1);
        out_last <= ((out_idx + IDX_WIDTH'(1)) == len_r);
      end
    end
  end

endmodule

// File: tb/tb_sqr_ref_gen.sv
// Directed bench for sqr_ref_gen: each frame's expected samples are queued at
// start from an independent modulo model and popped on every handshake.
module tb_sqr_ref_gen;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [8:0] cfg_len, cfg_period, cfg_duty, cfg_phase;
  logic       cfg_invert;
  logic [7:0] cfg_amp;
  logic [7:0] out_data;
  logic [8:0] out_idx;
  logic       out_valid, out_ready, out_last, busy, done;

  typedef struct {
    int data;
    int idx;
    int last;
  } smp_t;

  smp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sqr_ref_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_len    (cfg_len),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_phase  (cfg_phase),
    .cfg_invert (cfg_invert),
    .cfg_amp    (cfg_amp),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_level(input int amp, input int inv, input int high);
    int lo;
    lo = (amp == 0) ? 255 : 256 - amp;
    return ((high != 0) ^ (inv != 0)) ? amp : lo;
  endfunction

  // stop_kind: 0 run to completion, 1 abort at stop_at, 2 reset at stop_at.
  // glitch_at: index at which start is pulsed while the frame is running.
  task automatic run_frame(input int len, input int per, input int duty, input int ph,
                           input int inv, input int amp, input bit stall,
                           input int stop_kind, input int stop_at, input int glitch_at);
    int   pe, lat, cyc;
    bit   got_first, finished;
    smp_t s;
    pe = (per == 0) ? 1 : per;
    for (int i = 0; i <= len; i++) begin
      s.data = exp_level(amp, inv, (((ph % pe) + i) % pe) < duty);
      s.idx  = i;
      s.last = (i == len);
      sb.push_back(s);
    end
    @(negedge clk);
    cfg_len = 9'(len); cfg_period = 9'(per); cfg_duty = 9'(duty); cfg_phase = 9'(ph);
    cfg_invert = 1'(inv); cfg_amp = 8'(amp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_during_reduce", out_valid, 0);
    lat = 0; cyc = 0; got_first = 0; finished = 0;
    while (!finished && cyc < 3000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      if (out_valid) begin
        if (!got_first) begin
          got_first = 1;
          check("first_latency", lat, (ph / pe) + 1);
        end
        if (stop_kind != 0 && int'(out_idx) == stop_at) begin
          out_ready = 1'b1;
          if (stop_kind == 1) abort = 1'b1;
          else                rst   = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          rst   = 1'b0;
          check("stop_valid", out_valid, 0);
          check("stop_done", done, 0);
          check("stop_busy", busy, 0);
          if (stop_kind == 2) begin
            check("rst_data", out_data, 0);
            check("rst_idx", out_idx, 0);
            check("rst_last", out_last, 0);
          end
          sb.delete();
          finished = 1;
        end else begin
          if (int'(out_idx) == glitch_at) start = 1'b1;
          if (out_ready) begin
            if (sb.size() == 0) begin
              check("sb_underflow", sb.size(), 1);
              finished = 1;
            end else begin
              s = sb.pop_front();
              check("sample_data", out_data, s.data);
              check("sample_idx", out_idx, s.idx);
              check("sample_last", out_last, s.last);
              if (s.last != 0) begin
                @(negedge clk);
                start = 1'b0;
                check("done_pulse", done, 1);
                check("valid_after_last", out_valid, 0);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("done_cleared", done, 0);
                check("start_ignored_in_done", busy, 0);
                finished = 1;
              end
            end
          end
        end
      end
      if (!finished) begin
        @(negedge clk);
        lat++;
        cyc++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("frame_finished", finished, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cfg_len = '0; cfg_period = '0; cfg_duty = '0; cfg_phase = '0;
    cfg_invert = 1'b0; cfg_amp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_data", out_data, 0);
    check("reset_idx", out_idx, 0);
    check("reset_valid", out_valid, 0);
    check("reset_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // basic frame: 200,200,56,56,...
    run_frame(7, 4, 2, 0, 0, 200, 0, 0, -1, -1);
    // amp=0 saturates the low level to 255
    run_frame(3, 2, 1, 0, 0, 0, 0, 0, -1, -1);
    // phase 12 mod 5 = 2; first high at idx 3
    run_frame(7, 5, 2, 12, 0, 200, 0, 0, -1, -1);
    // random consumer stalls
    run_frame(7, 4, 2, 0, 0, 200, 1, 0, -1, -1);
    run_frame(20, 3, 1, 1, 1, 90, 1, 0, -1, -1);
    // abort at idx 3, then a clean frame
    run_frame(7, 4, 2, 0, 0, 200, 0, 1, 3, -1);
    run_frame(7, 4, 2, 0, 0, 200, 0, 0, -1, -1);
    // start pulsed mid-run is ignored, then reset at idx 4
    run_frame(9, 4, 2, 0, 0, 200, 0, 2, 4, 2);
    run_frame(5, 4, 2, 1, 0, 150, 0, 0, -1, 2);
    // edge configs: period 0, duty >= period, invert, single sample, long reduction
    run_frame(4, 0, 3, 0, 0, 100, 0, 0, -1, -1);
    run_frame(4, 4, 4, 0, 0, 200, 0, 0, -1, -1);
    run_frame(4, 4, 9, 0, 1, 200, 0, 0, -1, -1);
    run_frame(0, 3, 1, 0, 0, 77, 0, 0, -1, -1);
    run_frame(2, 1, 1, 300, 0, 30, 0, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
